// File: rtl/pipe_skid_reg_pkg.sv
// Shared types for the two-entry skid pipeline register.
package pipe_skid_reg_pkg;

    // Occupancy state; encodings match the legacy SKID_* defines.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b01,
        SKID_TWO   = 2'b10
    } skid_state_e;

    // Number of held entries for a given state.
    function automatic logic [1:0] skid_cnt(input skid_state_e state);
        case (state)
            SKID_ONE: skid_cnt = 2'd1;
            SKID_TWO: skid_cnt = 2'd2;
            default:  skid_cnt = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry valid/ready pipeline register. o_ready comes straight from the
// state register, so there is no combinational path from i_ready to o_ready.
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_flush,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_data,
    output logic [1:0]    o_cnt
);

    skid_state_e   state_q, state_d;
    logic [DW-1:0] main_q, skid_q;
    logic [DW-1:0] main_src;
    logic          ld_main, ld_skid;
    logic          push, pop;

    // Outputs decoded from the held state only.
    always_comb begin
        o_valid = (state_q != SKID_EMPTY);
        o_ready = (state_q != SKID_TWO);
        o_cnt   = skid_cnt(state_q);
        o_data  = main_q;
    end

    assign push = i_valid & o_ready;
    assign pop  = o_valid & i_ready;

    // Next state and register load strobes; flush voids both handshakes.
    always_comb begin
        state_d  = state_q;
        ld_main  = 1'b0;
        ld_skid  = 1'b0;
        main_src = i_data;
        if (i_flush) begin
            state_d = SKID_EMPTY;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (push) begin
                        state_d = SKID_ONE;
                        ld_main = 1'b1;
                    end
                end
                SKID_ONE: begin
                    if (push && !pop) begin
                        state_d = SKID_TWO;
                        ld_skid = 1'b1;
                    end else if (push && pop) begin
                        ld_main = 1'b1;
                    end else if (pop) begin
                        state_d = SKID_EMPTY;
                    end
                end
                SKID_TWO: begin
                    // Upstream is blocked here; only a pop can move us.
                    if (pop) begin
                        state_d  = SKID_ONE;
                        ld_main  = 1'b1;
                        main_src = skid_q;
                    end
                end
                default: state_d = SKID_EMPTY;
            endcase
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= SKID_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Data registers: cleared on reset/flush, otherwise enable-gated.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (i_flush) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (ld_main) main_q <= main_src;
            if (ld_skid) skid_q <= i_data;
        end
    end

endmodule
